// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbitration of ALU/LSU writebacks into one register-file
// write port, plus a 32-entry busy scoreboard for decode-stage hazard checks.
module rf_wb_arbiter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [4:0]      a_rd,
   input  logic [XLEN-1:0] a_data,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [4:0]      b_rd,
   input  logic [XLEN-1:0] b_data,
   input  logic            resv_valid,
   input  logic [4:0]      resv_rd,
   input  logic            flush,
   input  logic [4:0]      rs1_index,
   input  logic [4:0]      rs2_index,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            wb_en,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data
);
   logic            prio_q, prio_d;
   logic            wb_en_q, wb_en_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic [31:0]     busy_q, busy_d;
   logic            a_go, b_go;

   // An idle port is always ready; a contested cycle goes to the prio side.
   always_comb begin
      a_ready   = !b_valid || (a_valid && !prio_q);
      b_ready   = !a_valid || (b_valid && prio_q);
      a_go      = a_valid && a_ready;
      b_go      = b_valid && b_ready;
      prio_d    = a_go ? 1'b1 : b_go ? 1'b0 : prio_q;
      wb_en_d   = a_go ? (a_rd != 5'd0) : b_go ? (b_rd != 5'd0) : 1'b0;
      wb_rd_d   = !wb_en_d ? wb_rd_q : a_go ? a_rd : b_rd;
      wb_data_d = !wb_en_d ? wb_data_q : a_go ? a_data : b_data;
   end

   // Reservation is applied after the writeback clear so a same-index set wins.
   always_comb begin
      busy_d = busy_q;
      if (wb_en_q) busy_d[wb_rd_q] = 1'b0;
      if (resv_valid) busy_d[resv_rd] = 1'b1;
      if (flush) busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_rd_q   <= 5'd0;
         wb_data_q <= '0;
         busy_q    <= '0;
      end else begin
         prio_q    <= prio_d;
         wb_en_q   <= wb_en_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         busy_q    <= busy_d;
      end
   end

   assign rs1_busy = busy_q[rs1_index];
   assign rs2_busy = busy_q[rs2_index];
   assign wb_en    = wb_en_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table for rf_wb_arbiter plus hand-written
// sequences for async reset mid-transfer and post-reset arbitration.
module tb_rf_wb_arbiter;
   logic        clk, rst;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic [4:0]  a_rd, b_rd, resv_rd, rs1_index, rs2_index, wb_rd;
   logic [63:0] a_data, b_data, wb_data;
   logic        resv_valid, flush, rs1_busy, rs2_busy, wb_en;
   int          errors = 0;
   int          checks = 0;

   rf_wb_arbiter #(.XLEN(64)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .resv_valid(resv_valid), .resv_rd(resv_rd), .flush(flush),
      .rs1_index(rs1_index), .rs2_index(rs2_index),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [63:0] ad;
      logic        bv;
      logic [4:0]  brd;
      logic [63:0] bd;
      logic        rv;
      logic [4:0]  rrd;
      logic        fl;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        ar;
      logic        br;
      logic        r1b;
      logic        r2b;
      logic        en;
      logic [4:0]  rd;
      logic [63:0] dat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      a_valid = v.av; a_rd = v.ard; a_data = v.ad;
      b_valid = v.bv; b_rd = v.brd; b_data = v.bd;
      resv_valid = v.rv; resv_rd = v.rrd; flush = v.fl;
      rs1_index = v.rs1; rs2_index = v.rs2;
   endtask

   task automatic idle();
      a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
      resv_valid = 0; resv_rd = 0; flush = 0; rs1_index = 0; rs2_index = 0;
   endtask

   initial begin
      //                 av ard ad      bv brd bd      rv rrd fl rs1 rs2 ar br r1b r2b en rd  dat
      vecs.push_back(vec_t'{1, 5, 64'h11, 0, 0, 64'h0,  0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 5,  64'h11});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 5,  64'h11});
      vecs.push_back(vec_t'{0, 0, 64'h0,  1, 7, 64'h77, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 7,  64'h77});
      vecs.push_back(vec_t'{1, 3, 64'h33, 1, 7, 64'h77, 0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 3,  64'h33});
      vecs.push_back(vec_t'{1, 3, 64'h33, 1, 7, 64'h77, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 7,  64'h77});
      vecs.push_back(vec_t'{1, 3, 64'h33, 1, 7, 64'h77, 0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 3,  64'h33});
      vecs.push_back(vec_t'{1, 3, 64'h33, 1, 7, 64'h77, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 7,  64'h77});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  1, 9, 0, 9, 0,  1, 1, 0, 0,  0, 7,  64'h77});
      vecs.push_back(vec_t'{0, 0, 64'h0,  1, 9, 64'h99, 0, 0, 0, 9, 0,  0, 1, 1, 0,  1, 9,  64'h99});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  0, 0, 0, 9, 0,  1, 1, 1, 0,  0, 9,  64'h99});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  0, 0, 0, 9, 0,  1, 1, 0, 0,  0, 9,  64'h99});
      vecs.push_back(vec_t'{1, 12, 64'hC, 0, 0, 64'h0,  0, 0, 0, 12, 0, 1, 0, 0, 0,  1, 12, 64'hC});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  1, 12, 0, 12, 0, 1, 1, 0, 0, 0, 12, 64'hC});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  0, 0, 0, 12, 0, 1, 1, 1, 0,  0, 12, 64'hC});
      vecs.push_back(vec_t'{1, 0, 64'hFF, 0, 0, 64'h0,  1, 0, 0, 0, 12,  1, 0, 0, 1,  0, 12, 64'hC});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  0, 0, 0, 0, 12,  1, 1, 0, 1,  0, 12, 64'hC});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  1, 4, 0, 4, 8,   1, 1, 0, 0,  0, 12, 64'hC});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  1, 8, 0, 4, 8,   1, 1, 1, 0,  0, 12, 64'hC});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  1, 4, 1, 4, 8,   1, 1, 1, 1,  0, 12, 64'hC});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  0, 0, 0, 4, 12,  1, 1, 0, 0,  0, 12, 64'hC});
      vecs.push_back(vec_t'{1, 20, 64'h20, 0, 0, 64'h0, 1, 20, 1, 20, 0, 1, 0, 0, 0,  1, 20, 64'h20});
      vecs.push_back(vec_t'{0, 0, 64'h0,  0, 0, 64'h0,  0, 0, 0, 20, 0,  1, 1, 0, 0,  0, 20, 64'h20});

      rst = 1'b1;
      idle();
      #12;
      chk("reset wb_en", 64'(wb_en), 64'd0);
      chk("reset wb_rd", 64'(wb_rd), 64'd0);
      chk("reset wb_data", wb_data, 64'd0);
      chk("reset idle a_ready", 64'(a_ready), 64'd1);
      chk("reset idle b_ready", 64'(b_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d a_ready", i), 64'(a_ready), 64'(vecs[i].ar));
         chk($sformatf("v%0d b_ready", i), 64'(b_ready), 64'(vecs[i].br));
         chk($sformatf("v%0d rs1_busy", i), 64'(rs1_busy), 64'(vecs[i].r1b));
         chk($sformatf("v%0d rs2_busy", i), 64'(rs2_busy), 64'(vecs[i].r2b));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d wb_en", i), 64'(wb_en), 64'(vecs[i].en));
         chk($sformatf("v%0d wb_rd", i), 64'(wb_rd), 64'(vecs[i].rd));
         chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].dat);
      end

      // Async reset while a write is in flight; also leaves prio at 1 beforehand.
      @(negedge clk);
      idle();
      a_valid = 1; a_rd = 6; a_data = 64'h66; resv_valid = 1; resv_rd = 15; rs1_index = 15;
      @(posedge clk);
      #1;
      idle();
      rs1_index = 15;
      chk("inflight wb_en", 64'(wb_en), 64'd1);
      chk("inflight rs1_busy", 64'(rs1_busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("async rst wb_en", 64'(wb_en), 64'd0);
      chk("async rst wb_rd", 64'(wb_rd), 64'd0);
      chk("async rst wb_data", wb_data, 64'd0);
      chk("async rst rs1_busy", 64'(rs1_busy), 64'd0);

      // After reset the contested first cycle must go to A.
      @(negedge clk);
      rst = 1'b0;
      a_valid = 1; a_rd = 3; a_data = 64'h33; b_valid = 1; b_rd = 7; b_data = 64'h77;
      #1;
      chk("post-rst a_ready", 64'(a_ready), 64'd1);
      chk("post-rst b_ready", 64'(b_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("post-rst wb_rd", 64'(wb_rd), 64'd3);

      // An idle cycle must not move the pointer: B still wins next.
      @(negedge clk);
      idle();
      @(negedge clk);
      a_valid = 1; a_rd = 3; a_data = 64'h33; b_valid = 1; b_rd = 7; b_data = 64'h77;
      #1;
      chk("hold prio a_ready", 64'(a_ready), 64'd0);
      chk("hold prio b_ready", 64'(b_ready), 64'd1);
      @(posedge clk);
      #1;
      chk("hold prio wb_rd", 64'(wb_rd), 64'd7);
      chk("hold prio wb_data", wb_data, 64'h77);
      @(negedge clk);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: XLEN, 64, writeback data width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 a_valid / a_ready  in / out  1 / 1  ALU writeback handshake.
REQ-005 a_rd  in  5  ALU destination register index.
REQ-006 a_data  in  XLEN  ALU writeback data.
REQ-007 b_valid / b_ready  in / out  1 / 1  LSU writeback handshake.
REQ-008 b_rd  in  5  LSU destination register index.
REQ-009 b_data  in  XLEN  LSU writeback data.
REQ-010 resv_valid  in  1  issue stage reserves a destination register.
REQ-011 resv_rd  in  5  index being reserved.
REQ-012 flush  in  1  pipeline flush; drops all reservations.
REQ-013 rs1_index / rs2_index  in  5 / 5  decode-stage source indices.
REQ-014 rs1_busy / rs2_busy  out  1 / 1  source has a pending write.
REQ-015 wb_en  out  1  register-file write enable.
REQ-016 wb_rd  out  5  register-file write index.
REQ-017 wb_data  out  XLEN  register-file write data.

Function
REQ-018 Block SHALL accept at most one writeback per cycle; transfer occurs when valid && ready on that port.
REQ-019 Only one requester valid: that port's ready SHALL be 1, other port's ready 0.
REQ-020 Both valid: grant by round-robin pointer prio (0 = A preferred, 1 = B preferred); winner ready=1, loser ready=0.
REQ-021 prio SHALL become 1 after any A grant and 0 after any B grant; unchanged in cycles with no grant.
REQ-022 No requester valid: both readies SHALL be 1 (combinational, no valid-to-ready dependency beyond arbitration).
REQ-023 Accepted transfer in cycle N SHALL drive wb_en=1, wb_rd, wb_data registered during cycle N+1 (latency 1); otherwise wb_en=0 and wb_rd/wb_data hold last values.
REQ-024 Accepted transfer with rd==0 SHALL be consumed (ready honoured) but SHALL produce wb_en=0.
REQ-025 Scoreboard: 32-bit busy vector; resv_valid with resv_rd!=0 SHALL set busy[resv_rd] at next edge; resv_rd==0 ignored.
REQ-026 Edge where wb_en==1 SHALL clear busy[wb_rd].
REQ-027 Same-edge set and clear of same index: set SHALL win (busy stays 1).
REQ-028 busy[0] SHALL always read 0.
REQ-029 rs1_busy = busy[rs1_index], rs2_busy = busy[rs2_index], combinational, no bypass from pending wb_en.
REQ-030 flush SHALL clear all busy bits at next edge, overriding resv_valid in same cycle; in-flight output write (wb_en) SHALL still complete; handshakes unaffected.
REQ-031 Writeback to a non-busy register SHALL still be performed; busy clear is a no-op.

Reset
REQ-032 While rst=1: wb_en=0, wb_rd=0, wb_data=0, busy=all 0, prio=0, regardless of clk.
REQ-033 rst asserted mid-transfer SHALL drop any accepted-but-unwritten entry (wb_en forced 0 immediately).
REQ-034 First cycle after rst deassertion with both valid SHALL grant A.

Verification
REQ-035 Reset then a_valid=1,a_rd=5,a_data=0x11 one cycle -> next cycle wb_en=1,wb_rd=5,wb_data=0x11; following cycle wb_en=0.
REQ-036 a and b valid continuously, rd=3/7 -> grants alternate A,B,A,B; wb_rd sequence 3,7,3,7; loser ready=0 each cycle.
REQ-037 resv rd=9, later b writes rd=9 -> rs1_index=9 shows rs1_busy=1 until edge with wb_en=1,wb_rd=9, then 0.
REQ-038 Same cycle: wb_en=1 wb_rd=12 and resv_valid rd=12 -> busy[12] stays 1.
REQ-039 a_rd=0 with data 0xFF accepted -> a_ready=1, next cycle wb_en=0; resv rd=0 -> rs1_busy(rs1_index=0)=0.
REQ-040 Busy bits 4,8 set, flush with resv rd=4 same cycle -> all busy 0; async rst pulse mid-transfer -> wb_en=0 immediately.
